fnd_scan_decoder: RTL
=====================

Name: fnd_scan_decoder

Overview:
Passive monitor on a 4-digit multiplexed common-anode FND bus (seg, seg_comm). It samples the scanned segment patterns and filters out transition glitches. It inverse-decodes each pattern to a digit, assembles a full 4-slot frame, and converts the BCD digits to binary. Used for board loopback self-check and as a bench-side checker for any block that drives the display.

Parameters:
STABLE_CNT, 4, consecutive identical samples required before a slot is captured (>=2)
TIMEOUT, 1_000_000, clocks without any capture before partial frame is dropped (optional feature only)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
seg  input  8  segment pattern, active-low, bit7 = dp
seg_comm  input  4  digit enables, active-low; 1110 = ones ... 0111 = thousands
value  output  14  last successfully decoded value, 0..9999
valid  output  1  one-cycle pulse when value updates
frame_err  output  1  one-cycle pulse when a completed frame holds a non-decimal/illegal digit
busy  output  1  high while conversion is in progress
stale  output  1  one-cycle pulse on timeout drop (optional feature only)

Behaviour:
- Reset (reset==0 at clk edge): value=0, valid=0, frame_err=0, busy=0, stale=0, slot mask=0, stability counter=0, state IDLE. Reset mid-conversion aborts with no valid.
- Input stage: {seg,seg_comm} registered once. stab_cnt clears when the sample differs from the previous one, otherwise increments (saturating).
- Capture: occurs on the edge where stab_cnt reaches STABLE_CNT-1 and seg_comm has exactly one zero. One capture per stable period.
  - The digit is written into slot 0..3 and its mask bit is set.
  - A re-capture of a slot that is already set overwrites it (latest wins).
  - seg_comm values 1111 or multi-zero are never captured.
- Inverse decode, dp bit ignored (compare seg[6:0]):
  - C0,F9,A4,B0,99,92,82,F8,80,90 -> 0..9, legal.
  - 88,83,C6,A1,86,8E -> A..F, flagged error.
  - Any other pattern is flagged error.
- FSM IDLE -> CONV -> IDLE:
  - IDLE: when mask==1111, the next edge snapshots the four digits and error flags and clears the mask.
    - If any flag is set: frame_err pulses and the FSM stays IDLE.
    - Otherwise: go to CONV, acc=0, busy=1.
  - CONV: 4 edges, Horner order thousands->ones, acc = acc*10 + digit.
    - acc is 14 bits wide; the *10 is done as (acc<<3)+(acc<<1).
    - On the 4th edge: value<=result, valid pulses the following cycle, busy=0, return to IDLE.
- Latency: valid is high in the cycle after the 5th rising edge following the edge that captured the fourth slot.
- Capture continues during CONV into the cleared mask, so back-to-back frames are not lost.
- A completed mask during CONV is held until IDLE.
- Simultaneous capture and snapshot edge: the new capture goes to the fresh mask (snapshot uses the pre-edge slots).

Optional Feature:
FND_SCAN_DECODER_TIMEOUT_EN
- Defined: a counter increments every clock with no capture and resets on a capture. At TIMEOUT-1 with mask!=0, the mask is cleared and stale pulses one cycle.
- Undefined: no counter, stale is tied 0, and a partial frame persists indefinitely.

Decomposition:
- Shared package fnd_pkg holds:
  - the 16 segment-code constants;
  - the 4 seg_comm one-cold codes;
  - the state enum {IDLE, CONV};
  - the default STABLE_CNT and TIMEOUT.
- One sub-module, seg_to_digit: combinational, seg[6:0] -> digit[3:0] plus err.

Test Plan:
1. Scan 1234, each slot held 8 clocks (ones=99, tens=B0, hundreds=A4, thousands=F9) -> value=1234, single valid pulse, frame_err=0.
2. Scan 9999 then 0000 continuously -> value 9999 then 0, one valid per frame, no dropped frame across CONV.
3. Insert 2-clock glitch patterns (seg=80, seg_comm=1101) between slots with STABLE_CNT=4 -> glitches ignored, value=1234.
4. Hundreds slot shows 88 (A) -> frame_err pulse, no valid, value keeps previous 1234.
5. reset driven low on the 2nd CONV edge of frame 5678 -> value=0, busy=0, no valid; the next full frame 5678 decodes correctly.
6. With the macro defined and TIMEOUT=100: capture 2 slots, then idle 100 clocks -> stale pulse, mask cleared. Then a full frame 0042 -> value=42.

Source files
------------

// File: rtl/fnd_pkg.sv
// Shared constants for the FND scan decoder: segment codes, digit-enable codes,
// converter state encoding and parameter defaults.
package fnd_pkg;

    localparam int unsigned StableCntDefault = 4;
    localparam int unsigned TimeoutDefault   = 1_000_000;

    // Active-low segment codes on seg[6:0]; the dp bit is not part of the code
    localparam logic [6:0] Seg0 = 7'h40;
    localparam logic [6:0] Seg1 = 7'h79;
    localparam logic [6:0] Seg2 = 7'h24;
    localparam logic [6:0] Seg3 = 7'h30;
    localparam logic [6:0] Seg4 = 7'h19;
    localparam logic [6:0] Seg5 = 7'h12;
    localparam logic [6:0] Seg6 = 7'h02;
    localparam logic [6:0] Seg7 = 7'h78;
    localparam logic [6:0] Seg8 = 7'h00;
    localparam logic [6:0] Seg9 = 7'h10;
    localparam logic [6:0] SegA = 7'h08;
    localparam logic [6:0] SegB = 7'h03;
    localparam logic [6:0] SegC = 7'h46;
    localparam logic [6:0] SegD = 7'h21;
    localparam logic [6:0] SegE = 7'h06;
    localparam logic [6:0] SegF = 7'h0E;

    // One-cold digit enables
    localparam logic [3:0] CommOnes      = 4'b1110;
    localparam logic [3:0] CommTens      = 4'b1101;
    localparam logic [3:0] CommHundreds  = 4'b1011;
    localparam logic [3:0] CommThousands = 4'b0111;

    typedef enum logic {
        StIdle,
        StConv
    } conv_state_e;

endpackage

// File: rtl/seg_to_digit.sv
// Combinational inverse decoder: 7-segment active-low pattern to hex digit.
// err is set for A..F and for any pattern that is not a known digit code.
module seg_to_digit
    import fnd_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] digit_o,
    output logic       err_o
);

    // Decimal codes are legal; hex letters and unknown patterns raise err
    always_comb begin
        digit_o = 4'd0;
        err_o   = 1'b1;
        case (seg_i)
            Seg0: begin digit_o = 4'd0; err_o = 1'b0; end
            Seg1: begin digit_o = 4'd1; err_o = 1'b0; end
            Seg2: begin digit_o = 4'd2; err_o = 1'b0; end
            Seg3: begin digit_o = 4'd3; err_o = 1'b0; end
            Seg4: begin digit_o = 4'd4; err_o = 1'b0; end
            Seg5: begin digit_o = 4'd5; err_o = 1'b0; end
            Seg6: begin digit_o = 4'd6; err_o = 1'b0; end
            Seg7: begin digit_o = 4'd7; err_o = 1'b0; end
            Seg8: begin digit_o = 4'd8; err_o = 1'b0; end
            Seg9: begin digit_o = 4'd9; err_o = 1'b0; end
            SegA: digit_o = 4'hA;
            SegB: digit_o = 4'hB;
            SegC: digit_o = 4'hC;
            SegD: digit_o = 4'hD;
            SegE: digit_o = 4'hE;
            SegF: digit_o = 4'hF;
            default: digit_o = 4'd0;
        endcase
    end

endmodule

// File: rtl/fnd_scan_decoder.sv
// Passive monitor for a 4-digit multiplexed common-anode FND bus. Samples the
// scanned patterns, waits for STABLE_CNT identical samples before capturing a
// slot, assembles a 4-slot frame and converts the BCD digits to binary.
// Optional build macro FND_SCAN_DECODER_TIMEOUT_EN drops a partial frame after
// TIMEOUT clocks without a capture and pulses stale; otherwise stale is 0.
module fnd_scan_decoder
    import fnd_pkg::*;
#(
    parameter int unsigned STABLE_CNT = StableCntDefault,
    parameter int unsigned TIMEOUT    = TimeoutDefault
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  seg,
    input  logic [3:0]  seg_comm,
    output logic [13:0] value,
    output logic        valid,
    output logic        frame_err,
    output logic        busy,
    output logic        stale
);

    localparam int unsigned   StabW   = $clog2(STABLE_CNT);
    localparam logic [StabW-1:0] StabMax = StabW'(STABLE_CNT - 1);
    localparam logic [StabW-1:0] StabPre = StabW'(STABLE_CNT - 2);

    // ---------------- input stage ----------------
    logic [11:0]      samp_q;
    logic [StabW-1:0] stab_q;
    logic             same;

    assign same = ({seg, seg_comm} == samp_q);

    // Register the bus and count how long it has stayed unchanged
    always_ff @(posedge clk) begin
        if (!reset) begin
            samp_q <= '0;
            stab_q <= '0;
        end else begin
            samp_q <= {seg, seg_comm};
            if (!same) begin
                stab_q <= '0;
            end else if (stab_q != StabMax) begin
                stab_q <= stab_q + 1'b1;
            end
        end
    end

    // ---------------- capture ----------------
    logic [3:0] cap_sel;
    logic       cap;
    logic [3:0] cap_digit;
    logic       cap_err;

    // Slot select from the one-cold enable; anything else is never captured
    always_comb begin
        case (samp_q[3:0])
            CommOnes:      cap_sel = 4'b0001;
            CommTens:      cap_sel = 4'b0010;
            CommHundreds:  cap_sel = 4'b0100;
            CommThousands: cap_sel = 4'b1000;
            default:       cap_sel = 4'b0000;
        endcase
    end

    // Fires only on the edge the counter reaches its top, so once per stable period
    assign cap = same && (stab_q == StabPre) && (cap_sel != 4'b0000);

    seg_to_digit u_seg_to_digit (
        .seg_i   (samp_q[10:4]),
        .digit_o (cap_digit),
        .err_o   (cap_err)
    );

    logic [3:0][3:0] slot_dig_q;
    logic [3:0]      slot_err_q;
    logic [3:0]      mask_q;
    logic [3:0]      mask_d;
    logic            snap;
    logic            drop;
    conv_state_e     state_q;

    assign snap = (state_q == StIdle) && (mask_q == 4'b1111);

    // Snapshot frees the mask; a capture on that same edge lands in the fresh one
    always_comb begin
        mask_d = snap ? 4'b0000 : mask_q;
        if (cap) begin
            mask_d = mask_d | cap_sel;
        end
        if (drop) begin
            mask_d = 4'b0000;
        end
    end

    // Slot storage; a re-captured slot is simply overwritten
    always_ff @(posedge clk) begin
        if (!reset) begin
            slot_dig_q <= '0;
            slot_err_q <= '0;
            mask_q     <= '0;
        end else begin
            mask_q <= mask_d;
            for (int i = 0; i < 4; i++) begin
                if (cap && cap_sel[i]) begin
                    slot_dig_q[i] <= cap_digit;
                    slot_err_q[i] <= cap_err;
                end
            end
        end
    end

`ifdef FND_SCAN_DECODER_TIMEOUT_EN
    localparam int unsigned    ToW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT - 1);

    logic [ToW-1:0] to_q;
    logic           to_hit;
    logic           stale_q;

    assign to_hit = !cap && (to_q == ToLast);
    assign drop   = to_hit && (mask_q != 4'b0000) && !snap;

    // Idle-clock counter: restarts on every capture and whenever it expires
    always_ff @(posedge clk) begin
        if (!reset) begin
            to_q    <= '0;
            stale_q <= 1'b0;
        end else begin
            stale_q <= drop;
            if (cap || to_hit) begin
                to_q <= '0;
            end else begin
                to_q <= to_q + 1'b1;
            end
        end
    end

    assign stale = stale_q;
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT;
    assign drop           = 1'b0;
    assign stale          = 1'b0;
`endif

    // ---------------- BCD to binary converter ----------------
    logic [3:0][3:0] snap_dig_q;
    logic [1:0]      step_q;
    logic [13:0]     acc_q;
    logic [13:0]     acc_next;
    logic [3:0]      cur_digit;
    logic [13:0]     value_q;
    logic            valid_q;
    logic            frame_err_q;
    logic            busy_q;

    // Thousands first: step 0 reads slot 3
    assign cur_digit = snap_dig_q[2'd3 - step_q];
    assign acc_next  = (acc_q << 3) + (acc_q << 1) + 14'(cur_digit);

    // Converter FSM: snapshot a full frame, then four Horner steps
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            snap_dig_q  <= '0;
            step_q      <= '0;
            acc_q       <= '0;
            value_q     <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (snap) begin
                        snap_dig_q <= slot_dig_q;
                        if (|slot_err_q) begin
                            frame_err_q <= 1'b1;
                        end else begin
                            state_q <= StConv;
                            acc_q   <= '0;
                            step_q  <= '0;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                StConv: begin
                    acc_q  <= acc_next;
                    step_q <= step_q + 1'b1;
                    if (step_q == 2'd3) begin
                        value_q <= acc_next;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign value     = value_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule
